// File: rtl/conv1_weight_mac_rx.sv
// conv1_weight_mac_rx: receive end of the conv1 weight stream.
// Loads KERNEL_SIZE beats of 4 packed kernel weights, then computes one
// 4-lane signed dot product per KERNEL_SIZE-beat pixel window.
// Optional macro CONV1_MAC_RELU_EN: clamp negative lane results to 0.
module conv1_weight_mac_rx #(
    parameter int unsigned KERNEL_SIZE  = 32,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH    = WEIGHT_WIDTH + DATA_WIDTH + $clog2(KERNEL_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       c1_w_en,
    input  logic [4*WEIGHT_WIDTH-1:0]  c1_w,
    input  logic                       w_reload,
    output logic                       w_loaded,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [DATA_WIDTH-1:0]      pix_data,
    output logic                       out_valid,
    output logic [4*ACC_WIDTH-1:0]     conv_out
);

    localparam int unsigned NK = 4;
    localparam int unsigned CW = $clog2(KERNEL_SIZE);
    localparam int unsigned PW = WEIGHT_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {ST_LOAD, ST_READY, ST_ACC, ST_DONE} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  wcnt_q, wcnt_d;
    logic [CW-1:0]                  pcnt_q, pcnt_d;
    logic signed [WEIGHT_WIDTH-1:0] w_q [NK][KERNEL_SIZE];
    logic signed [WEIGHT_WIDTH-1:0] w_d [NK][KERNEL_SIZE];
    logic signed [ACC_WIDTH-1:0]    acc_q [NK];
    logic signed [ACC_WIDTH-1:0]    acc_d [NK];
    logic                           w_loaded_q, w_loaded_d;
    logic                           pix_ready_q, pix_ready_d;
    logic                           out_valid_q, out_valid_d;
    logic [NK*ACC_WIDTH-1:0]        conv_out_q, conv_out_d;

    logic                           pix_xfer_c;
    logic                           w_beat_c;
    logic                           last_w_c;
    logic                           last_p_c;
    logic [CW-1:0]                  tap_c;
    logic signed [PW-1:0]           prod_c [NK];

    assign pix_xfer_c = pix_valid && pix_ready_q;
    assign w_beat_c   = c1_w_en && (state_q == ST_LOAD) && !w_reload;
    assign last_w_c   = (wcnt_q == CW'(KERNEL_SIZE - 1));
    assign last_p_c   = (pcnt_q == CW'(KERNEL_SIZE - 1));

    assign w_loaded  = w_loaded_q;
    assign pix_ready = pix_ready_q;
    assign out_valid = out_valid_q;
    assign conv_out  = conv_out_q;

    // Per-lane signed product of the current tap weight and the pixel
    always_comb begin
        tap_c = (state_q == ST_READY) ? '0 : pcnt_q;
        for (int m = 0; m < NK; m++) begin
            prod_c[m] = PW'(w_q[m][tap_c]) * PW'($signed(pix_data));
        end
    end

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            wcnt_q      <= '0;
            pcnt_q      <= '0;
            w_loaded_q  <= 1'b0;
            pix_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            conv_out_q  <= '0;
            for (int m = 0; m < NK; m++) begin
                acc_q[m] <= '0;
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    w_q[m][k] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            pcnt_q      <= pcnt_d;
            w_loaded_q  <= w_loaded_d;
            pix_ready_q <= pix_ready_d;
            out_valid_q <= out_valid_d;
            conv_out_q  <= conv_out_d;
            acc_q       <= acc_d;
            w_q         <= w_d;
        end
    end

    // Next-state logic; reload overrides everything
    always_comb begin
        state_d = state_q;
        if (w_reload) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD:  if (w_beat_c && last_w_c)   state_d = ST_READY;
                ST_READY: if (pix_xfer_c)             state_d = ST_ACC;
                ST_ACC:   if (pix_xfer_c && last_p_c) state_d = ST_DONE;
                ST_DONE:                              state_d = ST_READY;
                default:                              state_d = ST_LOAD;
            endcase
        end
    end

    // Counters, weight bank, accumulators and registered outputs
    always_comb begin
        wcnt_d      = wcnt_q;
        pcnt_d      = pcnt_q;
        w_d         = w_q;
        acc_d       = acc_q;
        conv_out_d  = conv_out_q;
        w_loaded_d  = (state_d != ST_LOAD);
        pix_ready_d = (state_d == ST_READY) || (state_d == ST_ACC);
        out_valid_d = (state_d == ST_DONE);

        if (w_reload) begin
            wcnt_d = '0;
            pcnt_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (w_beat_c) begin
                        for (int m = 0; m < NK; m++) begin
                            w_d[m][wcnt_q] = c1_w[m*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                        end
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end
                ST_READY: begin
                    if (pix_xfer_c) begin
                        for (int m = 0; m < NK; m++) begin
                            acc_d[m] = ACC_WIDTH'(prod_c[m]);
                        end
                        pcnt_d = CW'(1);
                    end
                end
                ST_ACC: begin
                    if (pix_xfer_c) begin
                        for (int m = 0; m < NK; m++) begin
                            acc_d[m] = acc_q[m] + ACC_WIDTH'(prod_c[m]);
                        end
                        pcnt_d = pcnt_q + CW'(1);
                    end
                end
                default: begin
                    pcnt_d = '0;
                end
            endcase
        end

        // Result capture on DONE entry, including the final beat's product
        if (state_d == ST_DONE) begin
            for (int m = 0; m < NK; m++) begin
`ifdef CONV1_MAC_RELU_EN
                conv_out_d[m*ACC_WIDTH +: ACC_WIDTH] = acc_d[m][ACC_WIDTH-1] ? '0 : acc_d[m];
`else
                conv_out_d[m*ACC_WIDTH +: ACC_WIDTH] = acc_d[m];
`endif
            end
        end
    end

endmodule
